dsp_mac_sequencer: RTL and testbench

Sequencer that drives a DSP48A1-style multiply-accumulate slice built from pipeline-mux stages: input A/B register, M register, P register. It accepts a job length and a stream of operand pairs over a valid/ready handshake. It steps the slice's clock enables and OPMODE so the job's first product loads P and later products accumulate. After the pipeline drains it presents the final P value on a result handshake. It sits between the sample source and the slice and owns all of the slice's CE and OPMODE inputs.

---
 rtl/dsp_seq_pkg.sv | 20 ++
 rtl/dsp_mac_sequencer_tag_pipe.sv | 34 +++
 rtl/dsp_mac_sequencer.sv | 141 ++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP MAC sequencer: FSM states,
// slice OPMODE values and the {vld, first} tag carried alongside each operand.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam logic [7:0] OPM_MUL = 8'h01;
  localparam logic [7:0] OPM_MAC = 8'h09;

  typedef struct packed {
    logic vld;
    logic first;
  } tag_t;

endpackage

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// Two-stage {vld, first} shift register that mirrors the slice's M and P
// pipeline stages and turns each stage's tag into a CE / OPMODE.
module dsp_seq_tag_pipe
  import dsp_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       fire_i,
  input  logic       first_i,
  output logic       ce_m_o,
  output logic       ce_p_o,
  output logic [7:0] opmode_o
);

  tag_t s1_q;
  tag_t s2_q;

  // A bubble shifts an all-zero tag, so CE stays low and the slice holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q.vld   <= fire_i;
      s1_q.first <= fire_i & first_i;
      s2_q       <= s1_q;
    end
  end

  assign ce_m_o   = s1_q.vld;
  assign ce_p_o   = s2_q.vld;
  assign opmode_o = s2_q.first ? OPM_MUL : OPM_MAC;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequencer for a DSP48A1-style MAC slice: accepts a job length and operand
// stream, steps the slice CEs/OPMODE, and returns the final P on a result
// handshake. Optional macro DSP_SEQ_SAT_EN saturates the result and adds res_sat.
//
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high; valid, once raised, holds with stable data until that transfer.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int P_W   = 48,
  parameter int LEN_W = 8,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  output logic [A_W-1:0]   dsp_a,
  output logic [B_W-1:0]   dsp_b,
  output logic             dsp_ce_in,
  output logic             dsp_ce_m,
  output logic             dsp_ce_p,
  output logic [7:0]       dsp_opmode,
  input  logic [P_W-1:0]   dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
`ifdef DSP_SEQ_SAT_EN
  output logic             res_sat,
`endif
  output logic             done,
  output state_e           dbg_state
);

  state_e           state_q;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] rem_d;
  logic             first_q;
  logic             busy_q;
  logic             res_valid_q;
  logic             done_q;
  logic             fire;
  logic             ce_m;
  logic             ce_p;

  assign in_ready  = (state_q == ST_RUN);
  assign fire      = in_ready & in_valid;
  assign rem_d     = rem_q - LEN_W'(1);
  assign dsp_a     = in_a;
  assign dsp_b     = in_b;
  assign dsp_ce_in = fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      first_q     <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && (cfg_len != '0)) begin
            rem_q   <= cfg_len;
            first_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fire) begin
            rem_q   <= rem_d;
            first_q <= 1'b0;
            if (rem_q == LEN_W'(1)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Last product is in P stage with nothing behind it: P is final next cycle.
          if (ce_p && !ce_m) begin
            res_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dsp_seq_tag_pipe u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .fire_i   (fire),
    .first_i  (first_q),
    .ce_m_o   (ce_m),
    .ce_p_o   (ce_p),
    .opmode_o (dsp_opmode)
  );

  assign dsp_ce_m  = ce_m;
  assign dsp_ce_p  = ce_p;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign done      = done_q;
  assign dbg_state = state_q;

`ifdef DSP_SEQ_SAT_EN
  logic [P_W-OUT_W:0] hi_bits;
  logic               clip;

  // In range only when every bit above the result's sign bit matches it.
  assign hi_bits  = dsp_p[P_W-1:OUT_W-1];
  assign clip     = ~((&hi_bits) | ~(|hi_bits));
  assign res_data = !clip ? dsp_p[OUT_W-1:0] :
                    dsp_p[P_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                   {1'b0, {(OUT_W-1){1'b1}}};
  assign res_sat  = res_valid_q & clip;
`else
  logic unused_p_hi;

  assign unused_p_hi = ^dsp_p[P_W-1:OUT_W];
  assign res_data    = dsp_p[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer with a behavioural slice model and
// a job-level reference model; honours DSP_SEQ_SAT_EN when defined.
module tb_dsp_mac_sequencer;
  import dsp_seq_pkg::*;

  localparam int A_W   = 18;
  localparam int B_W   = 18;
  localparam int P_W   = 48;
  localparam int LEN_W = 8;
  localparam int OUT_W = 16;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [LEN_W-1:0]        cfg_len;
  logic                    busy;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [A_W-1:0]   in_a;
  logic signed [B_W-1:0]   in_b;
  logic [A_W-1:0]          dsp_a;
  logic [B_W-1:0]          dsp_b;
  logic                    dsp_ce_in;
  logic                    dsp_ce_m;
  logic                    dsp_ce_p;
  logic [7:0]              dsp_opmode;
  logic [P_W-1:0]          dsp_p;
  logic                    res_valid;
  logic                    res_ready;
  logic [OUT_W-1:0]        res_data;
`ifdef DSP_SEQ_SAT_EN
  logic                    res_sat;
`endif
  logic                    done;
  state_e                  dbg_state;

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;

  dsp_mac_sequencer #(
    .A_W(A_W), .B_W(B_W), .P_W(P_W), .LEN_W(LEN_W), .OUT_W(OUT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_len    (cfg_len),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_ce_in  (dsp_ce_in),
    .dsp_ce_m   (dsp_ce_m),
    .dsp_ce_p   (dsp_ce_p),
    .dsp_opmode (dsp_opmode),
    .dsp_p      (dsp_p),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
`ifdef DSP_SEQ_SAT_EN
    .res_sat    (res_sat),
`endif
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural slice ----------------
  logic signed [A_W-1:0] sa;
  logic signed [B_W-1:0] sb;
  logic signed [P_W-1:0] sm;
  logic signed [P_W-1:0] sp;

  initial begin
    sa = '0; sb = '0; sm = '0; sp = '0;
  end

  always @(posedge clk) begin
    if (dsp_ce_in) begin
      sa <= dsp_a;
      sb <= dsp_b;
    end
    if (dsp_ce_m) sm <= sa * sb;
    if (dsp_ce_p) sp <= (dsp_opmode == 8'h01) ? sm : sp + sm;
  end
  assign dsp_p = sp;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OUT_W-1:0] exp_res(input longint acc);
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (OUT_W - 1)) - 1;
    mn = -(longint'(1) <<< (OUT_W - 1));
`ifdef DSP_SEQ_SAT_EN
    if (acc > mx) return mx[OUT_W-1:0];
    if (acc < mn) return mn[OUT_W-1:0];
`endif
    return acc[OUT_W-1:0];
  endfunction

  function automatic bit exp_clip(input longint acc);
    longint mx;
    mx = (longint'(1) <<< (OUT_W - 1)) - 1;
    return (acc > mx) || (acc < -mx - 1);
  endfunction

  // Job-level model: what the sequencer must show, from the job's own history.
  bit        m_busy, m_done, f1, f2, ff1, ff2, last_sat;
  int        m_len, m_taken, done_cnt;
  longint    m_acc, m_last;
  logic [7:0] opm_q[$];

  initial begin
    m_busy = 0; m_done = 0; f1 = 0; f2 = 0; ff1 = 0; ff2 = 0; last_sat = 0;
    m_len = 0; m_taken = 0; done_cnt = 0; m_acc = 0; m_last = 0;
  end

  always @(negedge clk) begin
    bit acc_ok, fire, exp_rv;
    cyc++;
    if (rst) begin
      m_busy = 0; m_done = 0; m_len = 0; m_taken = 0;
      f1 = 0; f2 = 0; ff1 = 0; ff2 = 0;
    end
    acc_ok = m_busy && (m_taken < m_len);
    fire   = acc_ok && in_valid;
    exp_rv = m_busy && (m_len != 0) && (m_taken == m_len) && (cyc >= m_last + 3);

    check("busy", 64'(busy), 64'(m_busy));
    check("in_ready", 64'(in_ready), 64'(acc_ok));
    check("ce_in", 64'(dsp_ce_in), 64'(fire));
    check("ce_m", 64'(dsp_ce_m), 64'(f1));
    check("ce_p", 64'(dsp_ce_p), 64'(f2));
    check("opmode", 64'(dsp_opmode), (f2 && ff2) ? 64'h01 : 64'h09);
    check("res_valid", 64'(res_valid), 64'(exp_rv));
    check("done", 64'(done), 64'(m_done));
    if (exp_rv) check("res_data", 64'(res_data), 64'(exp_res(m_acc)));
`ifdef DSP_SEQ_SAT_EN
    check("res_sat", 64'(res_sat), 64'(exp_rv && exp_clip(m_acc)));
    if (res_valid) last_sat = res_sat;
`endif
    if (dsp_ce_p) opm_q.push_back(dsp_opmode);
    done_cnt += int'(done);

    m_done = 0;
    ff2 = ff1; f2 = f1;
    f1  = fire;
    ff1 = fire && (m_taken == 0);
    if (fire) begin
      m_acc += longint'(in_a) * longint'(in_b);
      m_taken++;
      if (m_taken == m_len) m_last = cyc;
    end
    if (exp_rv && res_ready) begin
      m_busy = 0;
      m_done = 1;
    end else if (!m_busy && !rst && start && (cfg_len != '0)) begin
      m_busy = 1; m_len = int'(cfg_len); m_taken = 0; m_acc = 0;
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job(input int len);
    start   = 1'b1;
    cfg_len = LEN_W'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input int a, input int b);
    bit got;
    got      = 0;
    in_a     = A_W'(a);
    in_b     = B_W'(b);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input int hold, input logic [OUT_W-1:0] lit, input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1;
    end
    if (!got) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check(name, 64'(res_data), 64'(lit));
      @(posedge clk);
      #1;
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
    end
  endtask

  task automatic check_opm3(input string name);
    check({name, "_cnt"}, 64'(opm_q.size()), 64'd3);
    if (opm_q.size() == 3) begin
      check({name, "_0"}, 64'(opm_q[0]), 64'h01);
      check({name, "_1"}, 64'(opm_q[1]), 64'h09);
      check({name, "_2"}, 64'(opm_q[2]), 64'h09);
    end
    opm_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_opmode", 64'(dsp_opmode), 64'h09);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    idle(2);
    opm_q.delete();

    // Continuous job: 2*3 + 4*5 + (-1)*7 = 19
    start_job(3);
    send(2, 3); send(4, 5); send(-1, 7);
    get_result(0, 16'd19, "job1_res");
    idle(2);
    check("job1_done_cnt", 64'(done_cnt), 64'd1);
    check_opm3("job1_opm");

    // Same job with 2-cycle bubbles and res_ready withheld for 5 cycles
    start_job(3);
    send(2, 3); idle(2); send(4, 5); idle(2); send(-1, 7);
    get_result(5, 16'd19, "job2_res");
    idle(2);
    check("job2_done_cnt", 64'(done_cnt), 64'd2);
    check_opm3("job2_opm");

    // Zero-length start is ignored; start while busy is ignored
    start_job(0);
    idle(3);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_done_cnt", 64'(done_cnt), 64'd2);
    start_job(2);
    send(1, 1);
    start_job(5);
    send(1, 1);
    get_result(0, 16'd2, "busy_start_res");
    idle(2);
    check("busy_start_done_cnt", 64'(done_cnt), 64'd3);

    // Reset after 1 of 4 operands aborts the job
    start_job(4);
    send(3, 3);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ce_m", 64'(dsp_ce_m), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    check("abort_done_cnt", 64'(done_cnt), 64'd3);
    start_job(1);
    send(6, 7);
    get_result(0, 16'd42, "after_abort_res");
    idle(2);
    check("after_abort_done_cnt", 64'(done_cnt), 64'd4);

    // 2 * 300*300 = 180000 overflows 16 bits
    start_job(2);
    send(300, 300); send(300, 300);
`ifdef DSP_SEQ_SAT_EN
    get_result(1, 16'h7FFF, "sat_res");
    check("sat_flag", 64'(last_sat), 64'd1);
`else
    get_result(1, 16'hBF20, "wrap_res");
`endif
    idle(3);
    check("final_done_cnt", 64'(done_cnt), 64'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
